// File: rtl/shift_cmd_sequencer.sv
// Purpose: sequences load/rotate/ASR commands into an external 8-bit shift register and returns its final value (optional abort via SHIFT_SEQ_ABORT_EN).
// Latency: accept at T -> result_valid high at T+3+N (N = shift count, forced to 0 for LOAD_ONLY).
// Backpressure: one command in flight; cmd_ready low from accept until the cycle after the result handshake, result held until result_ready.
module shift_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             reg_load_n,
    output logic             reg_rot_right,
    output logic             reg_as_right,
    output logic [WIDTH-1:0] reg_data,
    input  logic [WIDTH-1:0] reg_q,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam logic [1:0] OP_ROL  = 2'd0;
    localparam logic [1:0] OP_ASR  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_shadow;
    logic [WIDTH-1:0]  r_result;
    logic              w_abort;
    logic              w_accept;
    logic              w_res_hs;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept     = (r_state == S_IDLE) && cmd_valid;
    assign result_valid = (r_state == S_RESP);
    assign w_res_hs     = result_valid && result_ready;
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and register-control outputs; the register is re-loaded whenever it is not shifting.
    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        reg_load_n    = 1'b0;
        reg_rot_right = 1'b0;
        reg_as_right  = 1'b0;
        reg_data      = r_shadow;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                reg_data = r_data;
                if (w_abort || r_cnt == '0) w_next = S_CAPTURE;
                else                        w_next = S_SHIFT;
            end
            S_SHIFT: begin
                reg_load_n    = 1'b1;
                reg_rot_right = (r_op != OP_ROL);
                reg_as_right  = (r_op == OP_ASR);
                if (w_abort || r_cnt == CNT_W'(1)) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Feed Q straight back so the register holds while it is sampled.
                reg_data = reg_q;
                w_next   = S_RESP;
            end
            S_RESP: begin
                if (result_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, step down-counter, shadow copy and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_cnt  <= (cmd_op == OP_LOAD) ? '0 : cmd_count;
            end
            if (r_state == S_SHIFT) r_cnt <= r_cnt - CNT_W'(1);
            if (r_state == S_CAPTURE) begin
                r_result <= reg_q;
                r_shadow <= reg_q;
            end
        end
    end

`ifdef SHIFT_SEQ_ABORT_EN
    logic r_aborted;
    assign aborted = r_aborted;

    // Remember that the command was cut short; cleared when the result is consumed.
    always_ff @(posedge clk) begin
        if (reset)                                                           r_aborted <= 1'b0;
        else if (w_abort && (r_state == S_LOAD || r_state == S_SHIFT))       r_aborted <= 1'b1;
        else if (w_res_hs)                                                   r_aborted <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench: shift_cmd_sequencer driving a behavioural 8-bit load/rotate/ASR register.
// Latency: checks the accept-to-result_valid cycle counts.
// Backpressure: holds result_ready low and checks result, register and cmd_ready stay put.
module tb_shift_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_count = 4'd0;
    logic       reg_load_n, reg_rot_right, reg_as_right;
    logic [7:0] reg_data;
    logic [7:0] reg_q;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic [7:0] result;
    logic       busy;
    logic       abort_s = 1'b0;
    logic       aborted_s;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    bit rot_seen;

    always #5 clk = ~clk;

    shift_cmd_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_count    (cmd_count),
        .reg_load_n   (reg_load_n),
        .reg_rot_right(reg_rot_right),
        .reg_as_right (reg_as_right),
        .reg_data     (reg_data),
        .reg_q        (reg_q),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
`ifdef SHIFT_SEQ_ABORT_EN
        ,
        .abort        (abort_s),
        .aborted      (aborted_s)
`endif
    );

`ifndef SHIFT_SEQ_ABORT_EN
    assign aborted_s = 1'b0;
`endif

    // Behavioural model of the downstream register: no hold mode.
    always_ff @(posedge clk) begin
        if (reset)              reg_q <= 8'h00;
        else if (!reg_load_n)   reg_q <= reg_data;
        else if (reg_rot_right) reg_q <= reg_as_right ? {reg_q[7], reg_q[7:1]} : {reg_q[0], reg_q[7:1]};
        else                    reg_q <= {reg_q[6:0], reg_q[7]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one command and wait (bounded) for result_valid; abort_at > 0 raises abort in that cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [3:0] n,
                           input int abort_at, output int l, output bit rs);
        @(negedge clk);
        chk("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = n;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        l  = 1;
        rs = reg_rot_right;
        abort_s = (abort_at == 1);
        while (!result_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
            abort_s = (abort_at == l);
            rs = rs | reg_rot_right;
        end
        abort_s = 1'b0;
        chk("result_valid_seen", result_valid, 1);
    endtask

    task automatic ack();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("ack_result_valid_low", result_valid, 0);
        chk("ack_cmd_ready_high", cmd_ready, 1);
        chk("ack_busy_low", busy, 0);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_load_n", reg_load_n, 0);
        chk("rst_reg_data", reg_data, 8'h00);
        chk("rst_rot_right", reg_rot_right, 0);
        chk("rst_as_right", reg_as_right, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // ROR 0x81 by 1
        run_cmd(2'd1, 8'h81, 4'd1, 0, lat, rot_seen);
        chk("ror1_result", result, 8'hC0);
        chk("ror1_latency", lat, 4);
        ack();

        // ROL 0x81 by 1
        run_cmd(2'd0, 8'h81, 4'd1, 0, lat, rot_seen);
        chk("rol1_result", result, 8'h03);
        chk("rol1_no_rot_right", rot_seen, 0);
        ack();

        // ASR 0x80 by 3, ASR 0x40 by 2
        run_cmd(2'd2, 8'h80, 4'd3, 0, lat, rot_seen);
        chk("asr3_result", result, 8'hF0);
        chk("asr3_latency", lat, 6);
        ack();
        run_cmd(2'd2, 8'h40, 4'd2, 0, lat, rot_seen);
        chk("asr2_result", result, 8'h10);
        ack();

        // ASR saturation: 0x80 by 15 -> all sign bits
        run_cmd(2'd2, 8'h80, 4'd15, 0, lat, rot_seen);
        chk("asr15_result", result, 8'hFF);
        chk("asr15_latency", lat, 18);
        ack();

        // Full wrap: ROR 0xA5 by 8
        run_cmd(2'd1, 8'hA5, 4'd8, 0, lat, rot_seen);
        chk("ror8_result", result, 8'hA5);
        chk("ror8_latency", lat, 11);
        ack();

        // LOAD_ONLY ignores count
        run_cmd(2'd3, 8'h3C, 4'd9, 0, lat, rot_seen);
        chk("load_result", result, 8'h3C);
        chk("load_latency", lat, 3);
        chk("load_no_rot_right", rot_seen, 0);
        ack();

        // Backpressure: ROL 0x01 by 2, hold result 5 cycles
        run_cmd(2'd0, 8'h01, 4'd2, 0, lat, rot_seen);
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", result, 8'h04);
            chk("bp_reg_q", reg_q, 8'h04);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_result_valid", result_valid, 1);
            @(posedge clk); #1;
        end
        ack();
        chk("bp_idle_reg_q", reg_q, 8'h04);
        @(posedge clk); #1;
        chk("bp_idle_reg_q2", reg_q, 8'h04);

        // Reset during 2nd SHIFT cycle of ROR 0xF0 by 5
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'hF0; cmd_count = 4'd5;
        @(posedge clk); #1;          // LOAD
        cmd_valid = 1'b0;
        @(posedge clk); #1;          // SHIFT 1
        @(posedge clk); #1;          // SHIFT 2
        chk("mid_shifting", reg_load_n, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_result_valid", result_valid, 0);
        chk("mid_rst_load_n", reg_load_n, 0);
        chk("mid_rst_reg_data", reg_data, 8'h00);
        chk("mid_rst_reg_q", reg_q, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Recovery after reset
        run_cmd(2'd1, 8'h81, 4'd1, 0, lat, rot_seen);
        chk("post_rst_result", result, 8'hC0);
        ack();

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort raised in the 3rd SHIFT cycle (LOAD is cycle 1 after accept)
        run_cmd(2'd1, 8'h01, 4'd6, 4, lat, rot_seen);
        chk("abort_result", result, 8'h20);
        chk("abort_flag", aborted_s, 1);
        ack();
        chk("abort_flag_cleared", aborted_s, 0);
        run_cmd(2'd1, 8'h01, 4'd6, 0, lat, rot_seen);
        chk("noabort_result", result, 8'h04);
        chk("noabort_flag", aborted_s, 0);
        ack();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
